// File: rtl/riot_param.sv
// riot_param: RIOT-style I/O block with 1..4 bidirectional ports, an 8-bit prescaled timer and pin edge interrupts.
// Writes land on the access edge; read data and OE are registered, so they are valid one cycle after the address.
module riot_param #(
  parameter int PORTS  = 2,
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic                 phi2,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 we_n,
  input  logic [ADDR_W-1:0]    A,
  input  logic [7:0]           DI,
  output logic [7:0]           DO,
  output logic                 OE,
  output logic [8*PORTS-1:0]   PO,
  input  logic [8*PORTS-1:0]   PI,
  output logic [8*PORTS-1:0]   DDR,
  output logic                 irq_n
);

  localparam int              PW        = 8 * PORTS;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [7:0]      PMASK     = 8'((1 << PORTS) - 1);
  localparam logic [7:0]      CTRL_MASK = {PMASK[3:0], 4'hF};
  localparam logic [7:0]      IFR_MASK  = {PMASK[3:0], 4'h1};

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRED} tstate_e;

  logic [PW-1:0]    po_q, po_d, ddr_q, ddr_d;
  logic [PW-1:0]    sync1_q, sync2_q;
  logic [PORTS-1:0] hist_q, hist_d;
  logic [7:0]       ctrl_q, ctrl_d, ifr_q, ifr_d, epol_q, epol_d;
  logic [7:0]       count_q, count_d, reload_q, reload_d;
  logic [9:0]       presc_q, presc_d, period_m1;
  logic [1:0]       psel_q, psel_d;
  tstate_e          tstate_q, tstate_d;
  logic [7:0]       do_q, do_d;
  logic             oe_q, irq_n_q;

  logic       sel, wr, rd;
  logic       wr_timer, wr_ctrl, wr_ifr, wr_epol;
  logic       tick, tmr_set, irq_cond;
  logic [4:0] off;
  logic [7:0] rdata;
  logic [3:0] edge_set;

  assign off      = A[4:0];
  assign sel      = cs && (A[ADDR_W-1:5] == BASE_A[ADDR_W-1:5]);
  assign wr       = sel && !we_n;
  assign rd       = sel && we_n;
  assign wr_timer = wr && (off == 5'h10);
  assign wr_ctrl  = wr && (off == 5'h11);
  assign wr_ifr   = wr && (off == 5'h12);
  assign wr_epol  = wr && (off == 5'h13);

  always_comb begin
    po_d  = po_q;
    ddr_d = ddr_q;
    for (int p = 0; p < PORTS; p++) begin
      if (wr && (off[4:3] == 2'b00) && (off[2:1] == 2'(p))) begin
        if (off[0]) ddr_d[8*p +: 8] = DI;
        else        po_d[8*p +: 8]  = DI;
      end
    end
  end

  // Per bit: driven pins read back the output latch, input pins read the synchronized pin.
  always_comb begin
    rdata = 8'h00;
    for (int p = 0; p < PORTS; p++) begin
      if ((off[4:3] == 2'b00) && (off[2:1] == 2'(p))) begin
        if (off[0]) rdata = ddr_q[8*p +: 8];
        else        rdata = (po_q[8*p +: 8] & ddr_q[8*p +: 8]) |
                            (sync2_q[8*p +: 8] & ~ddr_q[8*p +: 8]);
      end
    end
    case (off)
      5'h10:   rdata = count_q;
      5'h11:   rdata = ctrl_q;
      5'h12:   rdata = ifr_q;
      5'h13:   rdata = epol_q;
      default: ;
    endcase
  end

  assign do_d = rd ? rdata : 8'h00;

  always_comb begin
    edge_set = 4'h0;
    hist_d   = hist_q;
    for (int p = 0; p < PORTS; p++) begin
      hist_d[p]   = sync2_q[8*p+7];
      edge_set[p] = epol_q[p] ? (sync2_q[8*p+7] & ~hist_q[p])
                              : (~sync2_q[8*p+7] & hist_q[p]);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    epol_d = epol_q;
    if (wr_ctrl) ctrl_d = DI & CTRL_MASK;
    if (wr_epol) epol_d = DI & PMASK;
  end

  // Clear first, then set, so a flag raised on the same edge as its clear survives.
  always_comb begin
    ifr_d = ifr_q;
    if (wr_ifr) ifr_d = ifr_q & ~DI;
    ifr_d = (ifr_d | {edge_set, 3'b000, tmr_set}) & IFR_MASK;
  end

  always_comb begin
    case (psel_q)
      2'd0:    period_m1 = 10'd0;
      2'd1:    period_m1 = 10'd7;
      2'd2:    period_m1 = 10'd63;
      default: period_m1 = 10'd1023;
    endcase
  end

  // The prescale selection is only re-sampled at a prescaler wrap while counting.
  always_comb begin
    tstate_d = tstate_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    psel_d   = psel_q;
    tmr_set  = 1'b0;
    tick     = (tstate_q == T_RUN) && (presc_q == period_m1);
    case (tstate_q)
      T_RUN: begin
        if (tick) begin
          presc_d = 10'd0;
          psel_d  = ctrl_q[1:0];
          if (count_q == 8'h00) begin
            tmr_set = 1'b1;
            if (ctrl_q[2]) count_d  = reload_q;
            else           tstate_d = T_EXPIRED;
          end else begin
            count_d = count_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + 10'd1;
        end
      end
      default: psel_d = ctrl_d[1:0];
    endcase
    if (wr_timer) begin
      count_d  = DI;
      reload_d = DI;
      presc_d  = 10'd0;
      psel_d   = ctrl_d[1:0];
      tstate_d = T_RUN;
      tmr_set  = 1'b0;
    end
  end

  assign irq_cond = (ifr_q[0] & ctrl_q[3]) | (|(ifr_q[7:4] & ctrl_q[7:4]));

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      po_q     <= '0;
      ddr_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      ctrl_q   <= 8'h00;
      ifr_q    <= 8'h00;
      epol_q   <= 8'h00;
      count_q  <= 8'h00;
      reload_q <= 8'h00;
      presc_q  <= 10'd0;
      psel_q   <= 2'd0;
      tstate_q <= T_IDLE;
      do_q     <= 8'h00;
      oe_q     <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      po_q     <= po_d;
      ddr_q    <= ddr_d;
      sync1_q  <= PI;
      sync2_q  <= sync1_q;
      hist_q   <= hist_d;
      ctrl_q   <= ctrl_d;
      ifr_q    <= ifr_d;
      epol_q   <= epol_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      psel_q   <= psel_d;
      tstate_q <= tstate_d;
      do_q     <= do_d;
      oe_q     <= rd;
      irq_n_q  <= ~irq_cond;
    end
  end

  assign PO    = po_q;
  assign DDR   = ddr_q;
  assign DO    = do_q;
  assign OE    = oe_q;
  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_riot_param.sv
// Directed bench for riot_param: reads push expected data into a queue, a monitor pops and compares on OE.
module tb_riot_param;
  localparam int PORTS  = 2;
  localparam int ADDR_W = 10;
  localparam int BASE   = 64;

  logic              phi2 = 1'b0;
  logic              rst, cs, we_n;
  logic [ADDR_W-1:0] A;
  logic [7:0]        DI, DO;
  logic              OE, irq_n;
  logic [15:0]       PO, PI, DDR;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {logic [4:0] off; logic [7:0] d;} exp_t;
  exp_t exp_q[$];

  riot_param #(.PORTS(PORTS), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
    .DO(DO), .OE(OE), .PO(PO), .PI(PI), .DDR(DDR), .irq_n(irq_n)
  );

  always #5 phi2 = ~phi2;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endfunction

  always @(posedge phi2) begin : mon
    exp_t e;
    #1;
    if (!rst) begin
      if (OE) begin
        if (exp_q.size() == 0) chk("unexpected_oe", 32'(OE), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("read_off_%0h", e.off), 32'(DO), 32'(e.d));
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_oe", 32'(OE), 32'd1);
      end
    end
  end

  task automatic wr(input logic [4:0] off, input logic [7:0] d);
    cs = 1'b1; we_n = 1'b0; A = ADDR_W'(BASE) + {5'b0, off}; DI = d;
    @(negedge phi2);
    cs = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] off, input logic [7:0] d);
    exp_t e;
    cs = 1'b1; we_n = 1'b1; A = ADDR_W'(BASE) + {5'b0, off};
    e.off = off; e.d = d;
    exp_q.push_back(e);
    @(negedge phi2);
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge phi2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cs = 1'b0; we_n = 1'b1; A = '0; DI = 8'h00; PI = 16'h003C;
    #2;
    chk("rst_po", 32'(PO), 32'h0);
    chk("rst_ddr", 32'(DDR), 32'h0);
    chk("rst_do", 32'(DO), 32'h0);
    chk("rst_oe", 32'(OE), 32'h0);
    chk("rst_irq_n", 32'(irq_n), 32'h1);
    idle(2);
    rst = 1'b0;
    idle(3);

    // Port data/direction and read-back mixing
    wr(5'h01, 8'hF0);
    wr(5'h00, 8'hA5);
    chk("po0", 32'(PO[7:0]), 32'hA5);
    chk("ddr0", 32'(DDR[7:0]), 32'hF0);
    chk("oe_on_write", 32'(OE), 32'h0);
    rd(5'h00, 8'hAC);
    idle(1);
    chk("oe_idle", 32'(OE), 32'h0);
    chk("do_idle", 32'(DO), 32'h0);
    wr(5'h03, 8'hFF);
    wr(5'h02, 8'h5A);
    rd(5'h02, 8'h5A);
    rd(5'h01, 8'hF0);

    // Absent port, unmapped offset, outside base, cs low
    wr(5'h07, 8'h55);
    chk("ddr_absent_port", 32'(DDR), 32'hFFF0);
    rd(5'h07, 8'h00);
    rd(5'h14, 8'h00);
    cs = 1'b1; we_n = 1'b0; A = 10'h000; DI = 8'h11;
    @(negedge phi2);
    cs = 1'b0; we_n = 1'b1;
    chk("po_outside_base", 32'(PO), 32'h5AA5);
    cs = 1'b0; we_n = 1'b0; A = 10'h040; DI = 8'h77;
    @(negedge phi2);
    we_n = 1'b1;
    chk("po_cs_low", 32'(PO), 32'h5AA5);
    cs = 1'b1; we_n = 1'b1; A = 10'h010;
    @(negedge phi2);
    cs = 1'b0;
    chk("oe_outside_base", 32'(OE), 32'h0);
    chk("do_outside_base", 32'(DO), 32'h0);
    rd(5'h00, 8'hAC);

    // One-shot, prescale 1, IRQ enabled: load 3 expires on the 4th tick
    wr(5'h11, 8'h08);
    wr(5'h10, 8'h03);
    idle(3);
    rd(5'h12, 8'h00);
    chk("irq_n_at_expiry", 32'(irq_n), 32'h1);
    idle(1);
    chk("irq_n_after_expiry", 32'(irq_n), 32'h0);
    rd(5'h12, 8'h01);
    rd(5'h10, 8'h00);
    rd(5'h11, 8'h08);
    wr(5'h12, 8'h01);
    idle(1);
    chk("irq_n_after_clear", 32'(irq_n), 32'h1);

    // Auto-reload, prescale 8, load 1: flag every 16 cycles; clear collides with set
    wr(5'h11, 8'h05);
    wr(5'h10, 8'h01);
    idle(15);
    rd(5'h12, 8'h00);
    rd(5'h12, 8'h01);
    wr(5'h12, 8'h01);
    idle(13);
    wr(5'h12, 8'h01);
    rd(5'h12, 8'h01);
    rd(5'h10, 8'h01);
    wr(5'h12, 8'h01);

    // Timer write on the expiry tick wins; no flag from that tick
    wr(5'h11, 8'h00);
    wr(5'h10, 8'h00);
    wr(5'h10, 8'h02);
    rd(5'h10, 8'h02);
    rd(5'h12, 8'h00);
    idle(1);
    rd(5'h12, 8'h01);
    wr(5'h12, 8'h01);
    chk("irq_n_timer_disabled", 32'(irq_n), 32'h1);

    // Falling edge on port 1 bit 7
    wr(5'h11, 8'h20);
    PI = 16'h803C;
    idle(4);
    rd(5'h12, 8'h00);
    PI = 16'h003C;
    idle(2);
    rd(5'h12, 8'h00);
    chk("irq_n_edge_set_edge", 32'(irq_n), 32'h1);
    idle(1);
    chk("irq_n_edge", 32'(irq_n), 32'h0);
    rd(5'h12, 8'h20);
    wr(5'h12, 8'h20);
    idle(1);
    chk("irq_n_edge_cleared", 32'(irq_n), 32'h1);

    // Rising edge on port 0 bit 7, EPOL/CTRL masking of absent ports
    wr(5'h13, 8'hFF);
    rd(5'h13, 8'h03);
    PI = 16'h00BC;
    idle(3);
    rd(5'h12, 8'h10);
    wr(5'h11, 8'hFF);
    rd(5'h11, 8'h3F);
    chk("irq_n_port0_edge", 32'(irq_n), 32'h0);
    wr(5'h12, 8'hFF);
    wr(5'h11, 8'h00);
    wr(5'h13, 8'h00);
    idle(1);
    chk("irq_n_all_clear", 32'(irq_n), 32'h1);

    // Reset in the middle of a long count
    wr(5'h11, 8'h0B);
    wr(5'h10, 8'h40);
    idle(50);
    rst = 1'b1;
    #1;
    chk("mid_rst_po", 32'(PO), 32'h0);
    chk("mid_rst_ddr", 32'(DDR), 32'h0);
    chk("mid_rst_do", 32'(DO), 32'h0);
    chk("mid_rst_oe", 32'(OE), 32'h0);
    chk("mid_rst_irq_n", 32'(irq_n), 32'h1);
    idle(3);
    rst = 1'b0;
    // Pin already high at release counts as a rising edge from the cleared history
    wr(5'h13, 8'h01);
    idle(2);
    rd(5'h12, 8'h10);
    rd(5'h10, 8'h00);
    rd(5'h11, 8'h00);
    idle(2);
    chk("post_rst_irq_n", 32'(irq_n), 32'h1);

    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
